cfi_queue_ctrl_mp: RTL and testbench

Multi-lane control-flow-integrity log push controller between the commit stage and the CFI log queue. Captures up to NR_COMMIT_PORTS acked CFI logs per cycle into a pending register. Drains up to NR_PUSH_PORTS of them per cycle, oldest first, limited by the free space the queue reports. Halts the core while pending logs remain, and adds flush and optional statistics.

---
 rtl/cfi_queue_ctrl_mp.sv | 85 ++++++++
 tb/tb_cfi_queue_ctrl_mp.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cfi_queue_ctrl_mp.sv
// cfi_queue_ctrl_mp: multi-lane CFI log push controller, oldest-first drain bounded by queue space.
// Define CFI_QUEUE_CTRL_STATS_EN to add saturating push/halt counters.
module cfi_queue_ctrl_mp #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int NR_PUSH_PORTS = 1,
  parameter int SPACE_W = 4,
  parameter type cfi_log_t = logic [31:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  input  cfi_log_t [NR_COMMIT_PORTS-1:0] log_i,
  input  logic [NR_COMMIT_PORTS-1:0] log_cfi_i,
  input  logic [NR_COMMIT_PORTS-1:0] log_ack_i,
  input  logic flush_i,
  input  logic [SPACE_W-1:0] queue_space_i,
  output logic [NR_PUSH_PORTS-1:0] queue_push_o,
  output cfi_log_t [NR_PUSH_PORTS-1:0] queue_data_o,
  output logic cfi_halt_o,
  output logic idle_o
`ifdef CFI_QUEUE_CTRL_STATS_EN
  ,
  output logic [31:0] push_cnt_o,
  output logic [31:0] halt_cnt_o
`endif
);
  localparam int XW = SPACE_W > 32 ? SPACE_W : 32;
  if (NR_PUSH_PORTS < 1 || NR_PUSH_PORTS > NR_COMMIT_PORTS) begin : g_bad_cfg
    $error("NR_PUSH_PORTS out of range");
  end
  logic [NR_COMMIT_PORTS-1:0] pend_v_q, pend_v_d, popped;
  cfi_log_t [NR_COMMIT_PORTS-1:0] pend_l_q, pend_l_d;
  logic [XW-1:0] sp;
  int cnt, lim, n, pushed;
  int rank [NR_COMMIT_PORTS];
  assign sp = XW'(queue_space_i);
  always_comb begin
    cnt = 0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      rank[i] = cnt;
      cnt = cnt + int'(pend_v_q[i]);
    end
    lim = (sp > XW'(NR_PUSH_PORTS)) ? NR_PUSH_PORTS : 32'(sp);
    n = cnt < lim ? cnt : lim;
    pushed = flush_i ? 0 : n;
    queue_push_o = '0;
    queue_data_o = '0;
    popped = '0;
    // rank[i] is the lane a pending log maps to, so lane order follows port order
    for (int k = 0; k < NR_PUSH_PORTS; k++)
      for (int i = 0; i < NR_COMMIT_PORTS; i++)
        if (pend_v_q[i] && rank[i] == k && k < pushed) begin
          queue_push_o[k] = 1'b1;
          queue_data_o[k] = pend_l_q[i];
          popped[i] = 1'b1;
        end
    cfi_halt_o = (cnt > n) && !flush_i;
    idle_o = cnt == 0;
    pend_v_d = flush_i ? '0 : cfi_halt_o ? pend_v_q & ~popped : log_cfi_i & log_ack_i;
    pend_l_d = (!flush_i && !cfi_halt_o) ? log_i : pend_l_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      pend_v_q <= '0;
      pend_l_q <= '0;
    end else begin
      pend_v_q <= pend_v_d;
      pend_l_q <= pend_l_d;
    end
`ifdef CFI_QUEUE_CTRL_STATS_EN
  logic [32:0] push_sum;
  assign push_sum = {1'b0, push_cnt_o} + 33'(pushed);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      push_cnt_o <= '0;
      halt_cnt_o <= '0;
    end else begin
      push_cnt_o <= push_sum[32] ? '1 : push_sum[31:0];
      halt_cnt_o <= (cfi_halt_o && ~&halt_cnt_o) ? halt_cnt_o + 32'd1 : halt_cnt_o;
    end
`endif
  a_thermo: assert property (@(posedge clk_i) disable iff (rst_i)
    (queue_push_o & (queue_push_o + 1'b1)) == '0);
  a_no_ack_halt: assert property (@(posedge clk_i) disable iff (rst_i)
    !(cfi_halt_o && |log_ack_i));
endmodule

// File: tb/tb_cfi_queue_ctrl_mp.sv
// tb_cfi_queue_ctrl_mp: directed vector bench for a 2x1 and a 4x2 instance of cfi_queue_ctrl_mp.
module tb_cfi_queue_ctrl_mp;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0][31:0] a_log;
  logic [1:0] a_cfi, a_ack;
  logic a_flush;
  logic [3:0] a_space;
  logic [0:0] a_push;
  logic [0:0][31:0] a_data;
  logic a_halt, a_idle;
  logic [3:0][31:0] b_log;
  logic [3:0] b_cfi, b_ack;
  logic b_flush;
  logic [3:0] b_space;
  logic [1:0] b_push;
  logic [1:0][31:0] b_data;
  logic b_halt, b_idle;
`ifdef CFI_QUEUE_CTRL_STATS_EN
  logic [31:0] a_pcnt, a_hcnt, b_pcnt, b_hcnt;
`endif
  cfi_queue_ctrl_mp #(.NR_COMMIT_PORTS(2), .NR_PUSH_PORTS(1), .SPACE_W(4)) u_a (
    .clk_i(clk), .rst_i(rst), .log_i(a_log), .log_cfi_i(a_cfi), .log_ack_i(a_ack),
    .flush_i(a_flush), .queue_space_i(a_space), .queue_push_o(a_push),
    .queue_data_o(a_data), .cfi_halt_o(a_halt), .idle_o(a_idle)
`ifdef CFI_QUEUE_CTRL_STATS_EN
    , .push_cnt_o(a_pcnt), .halt_cnt_o(a_hcnt)
`endif
  );
  cfi_queue_ctrl_mp #(.NR_COMMIT_PORTS(4), .NR_PUSH_PORTS(2), .SPACE_W(4)) u_b (
    .clk_i(clk), .rst_i(rst), .log_i(b_log), .log_cfi_i(b_cfi), .log_ack_i(b_ack),
    .flush_i(b_flush), .queue_space_i(b_space), .queue_push_o(b_push),
    .queue_data_o(b_data), .cfi_halt_o(b_halt), .idle_o(b_idle)
`ifdef CFI_QUEUE_CTRL_STATS_EN
    , .push_cnt_o(b_pcnt), .halt_cnt_o(b_hcnt)
`endif
  );
  typedef struct {
    logic [3:0] cfi;
    logic [3:0] ack;
    logic flush;
    logic [3:0] space;
    logic [1:0] push;
    logic [31:0] d0;
    logic [31:0] d1;
    logic halt;
    logic idle;
  } vec_t;
  vec_t vt [$];
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input logic push, input logic [31:0] d, input logic halt, input logic idle);
    chk({tag, " push"}, 32'(a_push), 32'(push));
    chk({tag, " data"}, a_data[0], d);
    chk({tag, " halt"}, 32'(a_halt), 32'(halt));
    chk({tag, " idle"}, 32'(a_idle), 32'(idle));
  endtask
  initial begin
    a_log = '0; a_cfi = '0; a_ack = '0; a_flush = 1'b0; a_space = 4'd8;
    b_log = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    b_cfi = '0; b_ack = '0; b_flush = 1'b0; b_space = 4'd8;
    // cfi, ack, flush, space | push, d0, d1, halt, idle
    vt.push_back('{4'b1011, 4'b1111, 1'b0, 4'd8, 2'b00, 32'h0,  32'h0,  1'b0, 1'b1});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd8, 2'b11, 32'hA0, 32'hB1, 1'b1, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd8, 2'b01, 32'hD3, 32'h0,  1'b0, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd8, 2'b00, 32'h0,  32'h0,  1'b0, 1'b1});
    vt.push_back('{4'b1011, 4'b1111, 1'b0, 4'd8, 2'b00, 32'h0,  32'h0,  1'b0, 1'b1});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd0, 2'b00, 32'h0,  32'h0,  1'b1, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd0, 2'b00, 32'h0,  32'h0,  1'b1, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd0, 2'b00, 32'h0,  32'h0,  1'b1, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd1, 2'b01, 32'hA0, 32'h0,  1'b1, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd1, 2'b01, 32'hB1, 32'h0,  1'b1, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd1, 2'b01, 32'hD3, 32'h0,  1'b0, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd8, 2'b00, 32'h0,  32'h0,  1'b0, 1'b1});
    vt.push_back('{4'b1011, 4'b1111, 1'b0, 4'd8, 2'b00, 32'h0,  32'h0,  1'b0, 1'b1});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd1, 2'b01, 32'hA0, 32'h0,  1'b1, 1'b0});
    vt.push_back('{4'b1111, 4'b1111, 1'b1, 4'd1, 2'b00, 32'h0,  32'h0,  1'b0, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd8, 2'b00, 32'h0,  32'h0,  1'b0, 1'b1});
    vt.push_back('{4'b0101, 4'b0011, 1'b0, 4'd8, 2'b00, 32'h0,  32'h0,  1'b0, 1'b1});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd8, 2'b01, 32'hA0, 32'h0,  1'b0, 1'b0});
    vt.push_back('{4'b0000, 4'b0000, 1'b0, 4'd8, 2'b00, 32'h0,  32'h0,  1'b0, 1'b1});
    #2;
    chk_a("reset a", 1'b0, 32'h0, 1'b0, 1'b1);
    chk("reset b push", 32'(b_push), 32'h0);
    chk("reset b idle", 32'(b_idle), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int i = 0; i < vt.size(); i++) begin
      b_cfi = vt[i].cfi; b_ack = vt[i].ack; b_flush = vt[i].flush; b_space = vt[i].space;
      #2;
      chk($sformatf("row%0d push", i), 32'(b_push), 32'(vt[i].push));
      chk($sformatf("row%0d d0", i), b_data[0], vt[i].d0);
      chk($sformatf("row%0d d1", i), b_data[1], vt[i].d1);
      chk($sformatf("row%0d halt", i), 32'(b_halt), 32'(vt[i].halt));
      chk($sformatf("row%0d idle", i), 32'(b_idle), 32'(vt[i].idle));
      step();
    end
    b_cfi = '0; b_ack = '0; b_flush = 1'b0; b_space = 4'd8;
    a_log = {32'h22, 32'h11}; a_cfi = 2'b11; a_ack = 2'b11;
    #2; chk_a("a c0", 1'b0, 32'h0, 1'b0, 1'b1); step();
    a_ack = 2'b00;
    #2; chk_a("a c1", 1'b1, 32'h11, 1'b1, 1'b0); step();
    a_log = {32'h44, 32'h33}; a_cfi = 2'b01; a_ack = 2'b11;
    #2; chk_a("a c2", 1'b1, 32'h22, 1'b0, 1'b0); step();
    a_ack = 2'b00;
    #2; chk_a("a c3", 1'b1, 32'h33, 1'b0, 1'b0); step();
    #2; chk_a("a c4", 1'b0, 32'h0, 1'b0, 1'b1); step();
    a_log = {32'h66, 32'h55}; a_cfi = 2'b11; a_ack = 2'b11;
    step();
    a_ack = 2'b00;
    #2; chk_a("a r1", 1'b1, 32'h55, 1'b1, 1'b0); step();
    #2; chk_a("a r2", 1'b1, 32'h66, 1'b0, 1'b0);
    rst = 1'b1;
    #1; chk_a("a async rst", 1'b0, 32'h0, 1'b0, 1'b1);
    step();
    #2; rst = 1'b0;
    #1; chk_a("a post rst", 1'b0, 32'h0, 1'b0, 1'b1); step();
    #2; chk_a("a post rst2", 1'b0, 32'h0, 1'b0, 1'b1); step();
`ifdef CFI_QUEUE_CTRL_STATS_EN
    chk("stats push rst", a_pcnt, 32'h0);
    chk("stats halt rst", a_hcnt, 32'h0);
    a_cfi = 2'b11; a_ack = 2'b11; step();
    a_ack = 2'b00; a_space = 4'd0; step();
    step();
    a_space = 4'd8; step();
    a_ack = 2'b11; step();
    a_ack = 2'b00; step();
    a_cfi = 2'b01; a_ack = 2'b01; step();
    a_ack = 2'b00; step();
    chk("stats push cnt", a_pcnt, 32'd5);
    chk("stats halt cnt", a_hcnt, 32'd4);
    force u_a.push_cnt_o = 32'hFFFF_FFFE;
    force u_a.halt_cnt_o = 32'hFFFF_FFFF;
    #1;
    release u_a.push_cnt_o;
    release u_a.halt_cnt_o;
    a_cfi = 2'b11; a_ack = 2'b11; step();
    a_ack = 2'b00; step();
    step();
    chk("stats push sat", a_pcnt, 32'hFFFF_FFFF);
    chk("stats halt sat", a_hcnt, 32'hFFFF_FFFF);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
